// File: rtl/warblade_pkg.sv
// Shared constants and types for the warblade sprite controllers.
package warblade_pkg;

  localparam int unsigned SCREEN_W  = 1024;
  localparam int unsigned SHIP_W    = 48;
  localparam int unsigned SHIP_YPOS = 680;
  localparam int unsigned SHIP_H    = 64;
  localparam int unsigned XPOS_W    = 12;
  // Rightmost legal left edge of the ship sprite.
  localparam int unsigned X_MAX     = SCREEN_W - SHIP_W;

  typedef enum logic [1:0] {
    StAlive,
    StDying,
    StInvuln,
    StGameOver
  } ship_state_e;

  typedef enum logic [1:0] {
    DirNone,
    DirLeft,
    DirRight
  } dir_e;

endpackage

// File: rtl/frame_tick_gen.sv
// Rising-edge detector on vertical blank: one-cycle registered pulse per frame.
module frame_tick_gen (
  input  logic clk,
  input  logic rst,
  input  logic vblnk,
  output logic frame_tick
);

  logic vblnk_q;
  logic tick_q;

  // vblnk_q resets high so a vblnk already high at reset does not produce a tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_q <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      vblnk_q <= vblnk;
      tick_q  <= vblnk & ~vblnk_q;
    end
  end

  assign frame_tick = tick_q;

endmodule

// File: rtl/ship_ctrl.sv
// Player ship controller: per-frame horizontal movement and life-cycle FSM.
module ship_ctrl
  import warblade_pkg::*;
#(
  parameter int unsigned X_START       = 488,
  parameter int unsigned MAX_SPEED     = 8,
  parameter int unsigned ACCEL_FRAMES  = 4,
  parameter int unsigned LIVES         = 3,
  parameter int unsigned DEATH_FRAMES  = 60,
  parameter int unsigned INVULN_FRAMES = 120,
  parameter int unsigned BLINK_PERIOD  = 8
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              vblnk,
  input  logic              btn_left,
  input  logic              btn_right,
  input  logic              btn_start,
  input  logic              hit,
  output logic [XPOS_W-1:0] xpos,
  output logic              ship_visible,
  output logic              invuln,
  output logic [1:0]        lives,
  output logic              game_over,
  output logic              frame_tick
);

  localparam int unsigned SpW      = $clog2(MAX_SPEED + 1);
  localparam int unsigned HoldW    = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
  localparam int unsigned FcMax    = (INVULN_FRAMES > DEATH_FRAMES) ? INVULN_FRAMES : DEATH_FRAMES;
  localparam int unsigned FcW      = $clog2(FcMax);
  localparam int unsigned BlinkBit = $clog2(BLINK_PERIOD);
  localparam int unsigned ExtW     = XPOS_W + 1;

  ship_state_e       state_q, state_d;
  logic [FcW-1:0]    frame_cnt_q, frame_cnt_d;
  logic [XPOS_W-1:0] xpos_q, xpos_d;
  logic [SpW-1:0]    speed_q, speed_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  dir_e              prev_dir_q, prev_dir_d;
  logic [1:0]        lives_q, lives_d;
  logic              vis_q, vis_d;
  logic              invuln_q, invuln_d;
  logic              game_over_q, game_over_d;

  dir_e              dir;
  logic [SpW-1:0]    mv_step;
  logic [SpW-1:0]    mv_speed;
  logic [HoldW-1:0]  mv_hold;
  logic [XPOS_W-1:0] mv_xpos;
  logic [ExtW-1:0]   x_ext;
  logic [ExtW-1:0]   s_ext;

  frame_tick_gen u_frame_tick_gen (
    .clk        (pclk),
    .rst        (rst),
    .vblnk      (vblnk),
    .frame_tick (frame_tick)
  );

  // Candidate movement result for this frame; only committed on a tick in a movable state.
  always_comb begin
    dir = DirNone;
    if (btn_left && !btn_right) begin
      dir = DirLeft;
    end else if (btn_right && !btn_left) begin
      dir = DirRight;
    end

    mv_speed = speed_q;
    mv_hold  = hold_q;
    mv_step  = speed_q;
    if (dir == DirNone) begin
      mv_speed = SpW'(1);
      mv_hold  = '0;
      mv_step  = '0;
    end else if (dir != prev_dir_q) begin
      mv_speed = SpW'(1);
      mv_hold  = '0;
      mv_step  = SpW'(1);
    end else if (hold_q == HoldW'(ACCEL_FRAMES - 1)) begin
      // Each speed lasts ACCEL_FRAMES held frames; the step after that uses the new speed.
      mv_hold  = '0;
      mv_speed = (speed_q >= SpW'(MAX_SPEED)) ? SpW'(MAX_SPEED) : speed_q + 1'b1;
      mv_step  = mv_speed;
    end else begin
      mv_hold  = hold_q + 1'b1;
      mv_step  = speed_q;
    end

    // Clamp in one extra bit so neither edge can wrap.
    x_ext   = {1'b0, xpos_q};
    s_ext   = ExtW'(mv_step);
    mv_xpos = xpos_q;
    if (dir == DirLeft) begin
      mv_xpos = (x_ext < s_ext) ? '0 : XPOS_W'(x_ext - s_ext);
    end else if (dir == DirRight) begin
      mv_xpos = (x_ext + s_ext > ExtW'(X_MAX)) ? XPOS_W'(X_MAX) : XPOS_W'(x_ext + s_ext);
    end
  end

  // Next-state logic: life cycle transitions, frame counting and movement commit.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    xpos_d      = xpos_q;
    speed_d     = speed_q;
    hold_d      = hold_q;
    prev_dir_d  = prev_dir_q;
    lives_d     = lives_q;

    unique case (state_q)
      StAlive: begin
        if (hit) begin
          lives_d     = lives_q - 2'd1;
          state_d     = (lives_q == 2'd1) ? StGameOver : StDying;
          frame_cnt_d = '0;
        end else if (frame_tick) begin
          xpos_d      = mv_xpos;
          speed_d     = mv_speed;
          hold_d      = mv_hold;
          prev_dir_d  = dir;
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end
      StDying: begin
        if (frame_tick) begin
          if (frame_cnt_q == FcW'(DEATH_FRAMES - 1)) begin
            state_d     = StInvuln;
            frame_cnt_d = '0;
            xpos_d      = XPOS_W'(X_START);
            speed_d     = SpW'(1);
            hold_d      = '0;
            prev_dir_d  = DirNone;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      StInvuln: begin
        if (frame_tick) begin
          xpos_d     = mv_xpos;
          speed_d    = mv_speed;
          hold_d     = mv_hold;
          prev_dir_d = dir;
          if (frame_cnt_q == FcW'(INVULN_FRAMES - 1)) begin
            state_d     = StAlive;
            frame_cnt_d = '0;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      StGameOver: begin
        if (frame_tick && btn_start) begin
          state_d     = StInvuln;
          frame_cnt_d = '0;
          lives_d     = 2'(LIVES);
          xpos_d      = XPOS_W'(X_START);
          speed_d     = SpW'(1);
          hold_d      = '0;
          prev_dir_d  = DirNone;
        end
      end
      default: state_d = StAlive;
    endcase
  end

  // Output decode from the next state so every output is a plain register.
  always_comb begin
    vis_d       = 1'b1;
    invuln_d    = 1'b0;
    game_over_d = 1'b0;
    unique case (state_d)
      StDying:    vis_d = 1'b0;
      StInvuln: begin
        invuln_d = 1'b1;
        vis_d    = ~frame_cnt_d[BlinkBit];
      end
      StGameOver: begin
        game_over_d = 1'b1;
        vis_d       = 1'b0;
      end
      default: ;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q     <= StAlive;
      frame_cnt_q <= '0;
      xpos_q      <= XPOS_W'(X_START);
      speed_q     <= SpW'(1);
      hold_q      <= '0;
      prev_dir_q  <= DirNone;
      lives_q     <= 2'(LIVES);
      vis_q       <= 1'b1;
      invuln_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      xpos_q      <= xpos_d;
      speed_q     <= speed_d;
      hold_q      <= hold_d;
      prev_dir_q  <= prev_dir_d;
      lives_q     <= lives_d;
      vis_q       <= vis_d;
      invuln_q    <= invuln_d;
      game_over_q <= game_over_d;
    end
  end

  assign xpos         = xpos_q;
  assign ship_visible = vis_q;
  assign invuln       = invuln_q;
  assign lives        = lives_q;
  assign game_over    = game_over_q;

endmodule

// File: tb/tb_ship_ctrl.sv
// Self-checking bench for ship_ctrl: frame-level behavioural model plus directed and random play.
module tb_ship_ctrl;

  localparam int X_START       = 488;
  localparam int X_MAX         = 976;
  localparam int MAX_SPEED     = 8;
  localparam int ACCEL_FRAMES  = 4;
  localparam int LIVES         = 3;
  localparam int DEATH_FRAMES  = 60;
  localparam int INVULN_FRAMES = 120;
  localparam int BLINK_PERIOD  = 8;

  localparam int PhAlive  = 0;
  localparam int PhDying  = 1;
  localparam int PhInvuln = 2;
  localparam int PhOver   = 3;

  logic        pclk;
  logic        rst;
  logic        vblnk;
  logic        btn_left;
  logic        btn_right;
  logic        btn_start;
  logic        hit;
  logic [11:0] xpos;
  logic        ship_visible;
  logic        invuln;
  logic [1:0]  lives;
  logic        game_over;
  logic        frame_tick;

  ship_ctrl dut (
    .pclk         (pclk),
    .rst          (rst),
    .vblnk        (vblnk),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_start    (btn_start),
    .hit          (hit),
    .xpos         (xpos),
    .ship_visible (ship_visible),
    .invuln       (invuln),
    .lives        (lives),
    .game_over    (game_over),
    .frame_tick   (frame_tick)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Model: what each output must be during the current cycle.
  int m_x, m_lives, m_phase, m_dy_left, m_inv_age, m_run_dir, m_run_len;
  bit m_tick, m_vb_prev;

  // Stimulus knobs.
  bit hit_on_tick = 1'b0;
  int hit_rate    = 0;
  int rst_rate    = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_x       = X_START;
    m_lives   = LIVES;
    m_phase   = PhAlive;
    m_dy_left = 0;
    m_inv_age = 0;
    m_run_dir = 0;
    m_run_len = 0;
    m_tick    = 1'b0;
    m_vb_prev = 1'b1;
  endtask

  task automatic model_respawn();
    m_phase   = PhInvuln;
    m_inv_age = 0;
    m_x       = X_START;
    m_run_dir = 0;
    m_run_len = 0;
  endtask

  // Speed is 1 for the first ACCEL_FRAMES held frames, 2 for the next ACCEL_FRAMES, ...
  task automatic model_move(input int d);
    int stp;
    if (d == 0) m_run_len = 0;
    else if (d != m_run_dir) m_run_len = 1;
    else if (m_run_len < 10000) m_run_len++;
    m_run_dir = d;
    if (d != 0) begin
      stp = 1 + (m_run_len - 1) / ACCEL_FRAMES;
      if (stp > MAX_SPEED) stp = MAX_SPEED;
      m_x = m_x + d * stp;
      if (m_x < 0) m_x = 0;
      if (m_x > X_MAX) m_x = X_MAX;
    end
  endtask

  // Advance the model across one clock edge using the inputs sampled at that edge.
  task automatic model_step();
    int d;
    bit t;
    if (rst) begin
      model_reset();
      return;
    end
    t = m_tick;
    d = (btn_left && !btn_right) ? -1 : ((btn_right && !btn_left) ? 1 : 0);
    case (m_phase)
      PhAlive: begin
        if (hit) begin
          m_lives--;
          if (m_lives == 0) m_phase = PhOver;
          else begin
            m_phase   = PhDying;
            m_dy_left = DEATH_FRAMES;
          end
        end else if (t) begin
          model_move(d);
        end
      end
      PhDying: begin
        if (t) begin
          m_dy_left--;
          if (m_dy_left == 0) model_respawn();
        end
      end
      PhInvuln: begin
        if (t) begin
          model_move(d);
          m_inv_age++;
          if (m_inv_age == INVULN_FRAMES) m_phase = PhAlive;
        end
      end
      default: begin
        if (t && btn_start) begin
          m_lives = LIVES;
          model_respawn();
        end
      end
    endcase
    m_tick    = vblnk && !m_vb_prev;
    m_vb_prev = vblnk;
  endtask

  function automatic int exp_visible();
    if (m_phase == PhAlive) return 1;
    if (m_phase == PhInvuln) return (((m_inv_age / BLINK_PERIOD) % 2) == 0) ? 1 : 0;
    return 0;
  endfunction

  // Per-cycle comparison of every output against the model, away from the active edge.
  always @(negedge pclk) begin
    if (chk_en) begin
      check("xpos", int'(xpos), m_x);
      check("lives", int'(lives), m_lives);
      check("frame_tick", int'(frame_tick), int'(m_tick));
      check("ship_visible", int'(ship_visible), exp_visible());
      check("invuln", int'(invuln), (m_phase == PhInvuln) ? 1 : 0);
      check("game_over", int'(game_over), (m_phase == PhOver) ? 1 : 0);
    end
  end

  // One clock: set per-cycle inputs, cross the edge, advance model, return at the negedge.
  task automatic step();
    hit = 1'b0;
    if (hit_on_tick && m_tick) begin
      hit         = 1'b1;
      hit_on_tick = 1'b0;
    end else if (hit_rate != 0 && $urandom_range(hit_rate - 1) == 0) begin
      hit = 1'b1;
    end
    rst = (rst_rate != 0 && $urandom_range(rst_rate - 1) == 0);
    @(posedge pclk);
    model_step();
    @(negedge pclk);
  endtask

  task automatic frame(input int lo, input int hi);
    vblnk = 1'b0;
    repeat (lo) step();
    vblnk = 1'b1;
    repeat (hi) step();
  endtask

  task automatic frames(input int n);
    repeat (n) frame(5, 3);
  endtask

  task automatic set_btn(input bit l, input bit r);
    btn_left  = l;
    btn_right = r;
  endtask

  int exp_steps[12] = '{1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3};
  int exp_x;

  initial begin
    rst = 1'b1; vblnk = 1'b1; btn_left = 1'b0; btn_right = 1'b0;
    btn_start = 1'b0; hit = 1'b0;
    model_reset();
    @(negedge pclk);
    // Reset held with vblnk high.
    @(posedge pclk); model_step(); @(negedge pclk);
    @(posedge pclk); model_step(); @(negedge pclk);
    chk_en = 1'b1;
    rst = 1'b0;
    repeat (3) step();
    check("reset_tick", int'(frame_tick), 0);
    check("reset_xpos", int'(xpos), 488);
    check("reset_lives", int'(lives), 3);
    check("reset_visible", int'(ship_visible), 1);
    check("reset_invuln", int'(invuln), 0);
    check("reset_game_over", int'(game_over), 0);

    // Acceleration while holding right.
    exp_x = 488;
    set_btn(1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      frame(5, 3);
      exp_x += exp_steps[i];
      check("accel_xpos", int'(xpos), exp_x);
    end
    check("accel_total", int'(xpos), 512);
    set_btn(1'b0, 1'b0);
    frames(1);
    check("release_xpos", int'(xpos), 512);
    set_btn(1'b0, 1'b1);
    frames(1);
    check("repress_xpos", int'(xpos), 513);

    // Edge clamps and both-button hold.
    set_btn(1'b1, 1'b0);
    frames(80);
    check("clamp_left", int'(xpos), 0);
    set_btn(1'b0, 1'b1);
    frames(160);
    check("clamp_right", int'(xpos), 976);
    set_btn(1'b1, 1'b1);
    frames(3);
    check("both_held", int'(xpos), 976);
    set_btn(1'b1, 1'b0);
    frames(1);
    check("left_from_edge", int'(xpos), 975);

    // Hit on the tick cycle while moving: no move that frame.
    set_btn(1'b0, 1'b1);
    hit_on_tick = 1'b1;
    frames(1);
    check("hit_lives", int'(lives), 2);
    check("hit_xpos", int'(xpos), 975);
    check("hit_visible", int'(ship_visible), 0);
    hit_on_tick = 1'b1;
    frames(1);
    check("dying_hit_lives", int'(lives), 2);
    set_btn(1'b0, 1'b0);
    frames(DEATH_FRAMES - 2);
    check("still_dying", int'(ship_visible), 0);
    frames(1);
    check("respawn_xpos", int'(xpos), 488);
    check("respawn_invuln", int'(invuln), 1);
    check("respawn_visible", int'(ship_visible), 1);
    hit_on_tick = 1'b1;
    frames(8);
    check("invuln_hit_lives", int'(lives), 2);
    check("blink_off", int'(ship_visible), 0);
    frames(8);
    check("blink_on", int'(ship_visible), 1);
    frames(INVULN_FRAMES - 16);
    check("alive_again_invuln", int'(invuln), 0);
    check("alive_again_visible", int'(ship_visible), 1);

    // Two more hits to game over, then restart.
    hit_on_tick = 1'b1;
    frames(1 + DEATH_FRAMES + INVULN_FRAMES);
    check("second_hit_lives", int'(lives), 1);
    check("second_alive", int'(invuln), 0);
    hit_on_tick = 1'b1;
    frames(2);
    check("over_lives", int'(lives), 0);
    check("over_flag", int'(game_over), 1);
    check("over_visible", int'(ship_visible), 0);
    btn_start = 1'b1;
    frames(1);
    btn_start = 1'b0;
    check("restart_lives", int'(lives), 3);
    check("restart_invuln", int'(invuln), 1);
    check("restart_xpos", int'(xpos), 488);
    frames(INVULN_FRAMES);

    // Reset while dying.
    hit_on_tick = 1'b1;
    frames(5);
    check("pre_rst_visible", int'(ship_visible), 0);
    vblnk = 1'b0;
    rst_rate = 1;
    step();
    rst_rate = 0;
    check("rst_lives", int'(lives), 3);
    check("rst_xpos", int'(xpos), 488);
    check("rst_visible", int'(ship_visible), 1);
    check("rst_invuln", int'(invuln), 0);
    check("rst_game_over", int'(game_over), 0);

    // Random play against the model.
    hit_rate = 250;
    for (int f = 0; f < 1500; f++) begin
      if ($urandom_range(1) == 0) begin
        case ($urandom_range(3))
          0: set_btn(1'b0, 1'b0);
          1: set_btn(1'b1, 1'b0);
          2: set_btn(1'b0, 1'b1);
          default: set_btn(1'b1, 1'b1);
        endcase
      end
      btn_start = ($urandom_range(3) == 0);
      rst_rate  = (f % 300 == 299) ? 4 : 0;
      frame($urandom_range(8, 2), $urandom_range(4, 1));
    end
    rst_rate = 0;
    hit_rate = 0;
    frames(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
